// File: rtl/eth_mii_rx_frame.sv
// MII receive deframer: finds preamble/SFD, extracts the MAC header, streams payload
// with the FCS held back, and flags CRC/length/symbol errors on the final payload beat.
module eth_mii_rx_frame #(
   parameter int P_MIN_FRAME_BYTES = 64,
   parameter int P_MAX_FRAME_BYTES = 1518
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  i_mii_rxd,
   input  logic        i_mii_rx_dv,
   input  logic        i_mii_rx_er,
   output logic [47:0] o_dst_mac,
   output logic [47:0] o_src_mac,
   output logic [15:0] o_frame_type,
   output logic        o_hdr_valid,
   output logic [7:0]  o_data,
   output logic        o_valid,
   output logic        o_last,
   output logic        o_error,
   output logic        o_frame_drop
);

   localparam int CNT_W = $clog2(P_MAX_FRAME_BYTES + 2);
   localparam logic [CNT_W-1:0] L_HDR_LAST = CNT_W'(13);
   localparam logic [CNT_W-1:0] L_MIN      = CNT_W'(P_MIN_FRAME_BYTES);
   localparam logic [CNT_W-1:0] L_MAX      = CNT_W'(P_MAX_FRAME_BYTES);
   localparam logic [CNT_W-1:0] L_SAT      = CNT_W'(P_MAX_FRAME_BYTES + 1);
   localparam logic [31:0]      L_RESIDUE  = 32'hDEBB20E3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PREAMBLE,
      S_HEADER,
      S_PAYLOAD,
      S_DROP
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic             r_armed;
   logic             r_phase;
   logic [3:0]       r_low;
   logic [31:0]      r_crc;
   logic [CNT_W-1:0] r_byte_cnt;
   logic             r_err;
   logic [111:0]     r_hdr_sr;
   logic [7:0]       r_pay [0:4];
   logic [2:0]       r_pay_cnt;

   logic             w_in_frame;
   logic             w_byte_done;
   logic [7:0]       w_byte;
   logic [111:0]     w_hdr;
   logic             w_sfd;
   logic             w_eof;
   logic             w_hdr_done;
   logic             w_emit;
   logic             w_emit_last;
   logic             w_drop;
   logic             w_frame_err;

   // Reflected CRC-32, one byte, LSB first, no final inversion.
   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] x;
      x = c;
      for (int i = 0; i < 8; i++) begin
         x = (x[0] ^ d[i]) ? ((x >> 1) ^ 32'hEDB88320) : (x >> 1);
      end
      return x;
   endfunction

   assign w_in_frame  = (r_state == S_HEADER) || (r_state == S_PAYLOAD);
   assign w_byte      = {i_mii_rxd, r_low};
   assign w_hdr       = {r_hdr_sr[103:0], w_byte};
   assign w_frame_err = r_err || r_phase || (r_crc != L_RESIDUE) ||
                        (r_byte_cnt < L_MIN) || (r_byte_cnt > L_MAX);

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (r_armed && i_mii_rx_dv)
               w_next = (i_mii_rxd == 4'h5) ? S_PREAMBLE : S_DROP;
         end
         S_PREAMBLE: begin
            if (!i_mii_rx_dv)              w_next = S_IDLE;
            else if (i_mii_rx_er)          w_next = S_DROP;
            else if (i_mii_rxd == 4'hD)    w_next = S_HEADER;
            else if (i_mii_rxd != 4'h5)    w_next = S_DROP;
         end
         S_HEADER: begin
            if (!i_mii_rx_dv)              w_next = S_IDLE;
            else if (w_hdr_done)           w_next = S_PAYLOAD;
         end
         S_PAYLOAD, S_DROP: begin
            if (!i_mii_rx_dv)              w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_byte_done = w_in_frame && i_mii_rx_dv && r_phase;
      w_sfd       = (r_state == S_PREAMBLE) && i_mii_rx_dv && !i_mii_rx_er &&
                    (i_mii_rxd == 4'hD);
      w_eof       = w_in_frame && !i_mii_rx_dv;
      w_hdr_done  = (r_state == S_HEADER) && w_byte_done && (r_byte_cnt == L_HDR_LAST);
      w_emit      = (r_state == S_PAYLOAD) && w_byte_done && (r_pay_cnt == 3'd5);
      w_emit_last = w_eof && (r_pay_cnt == 3'd5);
      w_drop      = (((r_state == S_PREAMBLE) || (r_state == S_DROP)) && !i_mii_rx_dv) ||
                    (w_eof && (r_pay_cnt != 3'd5));
   end

   // The last four post-header bytes are the FCS, so payload lags the wire by five bytes.
   always_ff @(posedge clk) begin
      if ((r_state == S_PAYLOAD) && w_byte_done) begin
         r_pay[0] <= w_byte;
         for (int i = 1; i < 5; i++) r_pay[i] <= r_pay[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_armed      <= 1'b0;
         r_phase      <= 1'b0;
         r_low        <= 4'h0;
         r_crc        <= 32'hFFFFFFFF;
         r_byte_cnt   <= '0;
         r_err        <= 1'b0;
         r_hdr_sr     <= '0;
         r_pay_cnt    <= 3'd0;
         o_dst_mac    <= 48'h0;
         o_src_mac    <= 48'h0;
         o_frame_type <= 16'h0;
         o_hdr_valid  <= 1'b0;
         o_data       <= 8'h0;
         o_valid      <= 1'b0;
         o_last       <= 1'b0;
         o_error      <= 1'b0;
         o_frame_drop <= 1'b0;
      end else begin
         if (!i_mii_rx_dv) r_armed <= 1'b1;
         o_hdr_valid  <= 1'b0;
         o_valid      <= 1'b0;
         o_last       <= 1'b0;
         o_error      <= 1'b0;
         o_frame_drop <= w_drop;

         if (w_sfd) begin
            r_phase    <= 1'b0;
            r_byte_cnt <= '0;
            r_crc      <= 32'hFFFFFFFF;
            r_err      <= 1'b0;
            r_pay_cnt  <= 3'd0;
         end

         if (w_in_frame && i_mii_rx_dv) begin
            if (i_mii_rx_er) r_err <= 1'b1;
            if (!r_phase) begin
               r_low   <= i_mii_rxd;
               r_phase <= 1'b1;
            end else begin
               r_phase <= 1'b0;
               r_crc   <= crc_byte(r_crc, w_byte);
               if (r_byte_cnt != L_SAT) r_byte_cnt <= r_byte_cnt + 1'b1;
               if (r_state == S_HEADER) r_hdr_sr <= w_hdr;
               if ((r_state == S_PAYLOAD) && (r_pay_cnt != 3'd5))
                  r_pay_cnt <= r_pay_cnt + 3'd1;
            end
         end

         if (w_hdr_done) begin
            o_dst_mac    <= w_hdr[111:64];
            o_src_mac    <= w_hdr[63:16];
            o_frame_type <= w_hdr[15:0];
            o_hdr_valid  <= 1'b1;
         end

         if (w_emit || w_emit_last) begin
            o_data  <= r_pay[4];
            o_valid <= 1'b1;
         end
         if (w_emit_last) begin
            o_last  <= 1'b1;
            o_error <= w_frame_err;
         end
      end
   end

endmodule

// File: tb/tb_eth_mii_rx_frame.sv
// Randomised frame bench for eth_mii_rx_frame; expectations come from a frame-level model
// built on the byte list that is put on the wire.
module tb_eth_mii_rx_frame;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  rxd;
   logic        dv;
   logic        er;
   logic [47:0] o_dst_mac;
   logic [47:0] o_src_mac;
   logic [15:0] o_frame_type;
   logic        o_hdr_valid;
   logic [7:0]  o_data;
   logic        o_valid;
   logic        o_last;
   logic        o_error;
   logic        o_frame_drop;

   always #5 clk = ~clk;

   eth_mii_rx_frame #(.P_MIN_FRAME_BYTES(64), .P_MAX_FRAME_BYTES(1518)) dut (
      .clk          (clk),
      .rst          (rst),
      .i_mii_rxd    (rxd),
      .i_mii_rx_dv  (dv),
      .i_mii_rx_er  (er),
      .o_dst_mac    (o_dst_mac),
      .o_src_mac    (o_src_mac),
      .o_frame_type (o_frame_type),
      .o_hdr_valid  (o_hdr_valid),
      .o_data       (o_data),
      .o_valid      (o_valid),
      .o_last       (o_last),
      .o_error      (o_error),
      .o_frame_drop (o_frame_drop)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Observed output events
   logic [7:0]  got_beats[$];
   int          got_last_cnt, got_last_idx, got_hdr_cnt, got_drop_cnt;
   logic        got_err;
   logic [47:0] got_dst, got_src;
   logic [15:0] got_type;

   always @(negedge clk) begin
      if (o_valid) begin
         got_beats.push_back(o_data);
         if (o_last) begin
            got_last_cnt++;
            got_last_idx = got_beats.size() - 1;
            got_err = o_error;
         end
      end
      if (o_hdr_valid) begin
         got_hdr_cnt++;
         got_dst  = o_dst_mac;
         got_src  = o_src_mac;
         got_type = o_frame_type;
      end
      if (o_frame_drop) got_drop_cnt++;
   end

   task automatic clear_got();
      got_beats.delete();
      got_last_cnt = 0;
      got_last_idx = -1;
      got_hdr_cnt  = 0;
      got_drop_cnt = 0;
      got_err      = 1'b0;
   endtask

   // Expected events for the frame most recently put on the wire
   logic [7:0]  tx_q[$];
   logic [7:0]  exp_beats[$];
   int          exp_hdr, exp_drop;
   logic        exp_err;
   logic [47:0] exp_dst, exp_src;
   logic [15:0] exp_type;
   bit          pending = 0;

   function automatic logic [31:0] fcs_of(input int n);
      logic [31:0] c;
      c = 32'hFFFFFFFF;
      for (int i = 0; i < n; i++)
         for (int b = 0; b < 8; b++)
            c = (c[0] ^ tx_q[i][b]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      return ~c;
   endfunction

   task automatic build_frame(input logic [47:0] dst, input logic [47:0] src,
                              input logic [15:0] typ, input int plen,
                              input bit incr, input bit bad_fcs);
      logic [31:0] f;
      tx_q.delete();
      for (int i = 0; i < 6; i++) tx_q.push_back(dst[47-8*i -: 8]);
      for (int i = 0; i < 6; i++) tx_q.push_back(src[47-8*i -: 8]);
      tx_q.push_back(typ[15:8]);
      tx_q.push_back(typ[7:0]);
      for (int i = 0; i < plen; i++) tx_q.push_back(incr ? 8'(i) : 8'($urandom));
      f = fcs_of(tx_q.size());
      for (int i = 0; i < 4; i++) tx_q.push_back(f[8*i +: 8]);
      if (bad_fcs) tx_q[tx_q.size()-4] = tx_q[tx_q.size()-4] ^ 8'h01;
   endtask

   task automatic set_expect(input bit bad_pre, input bit er_inj, input bit dribble);
      int L;
      bit fcs_ok;
      L = tx_q.size();
      exp_beats.delete();
      exp_hdr = 0; exp_drop = 0; exp_err = 1'b0;
      if (bad_pre) begin
         exp_drop = 1;
      end else if (L < 14) begin
         exp_drop = 1;
      end else begin
         exp_hdr  = 1;
         exp_dst  = {tx_q[0], tx_q[1], tx_q[2], tx_q[3], tx_q[4], tx_q[5]};
         exp_src  = {tx_q[6], tx_q[7], tx_q[8], tx_q[9], tx_q[10], tx_q[11]};
         exp_type = {tx_q[12], tx_q[13]};
         if (L - 14 < 5) begin
            exp_drop = 1;
         end else begin
            for (int i = 14; i <= L - 5; i++) exp_beats.push_back(tx_q[i]);
            fcs_ok  = (fcs_of(L - 4) == {tx_q[L-1], tx_q[L-2], tx_q[L-3], tx_q[L-4]});
            exp_err = er_inj || dribble || !fcs_ok || (L < 64) || (L > 1518);
         end
      end
   endtask

   task automatic compare_pending();
      int m;
      check_val("hdr_cnt", got_hdr_cnt, exp_hdr);
      if (exp_hdr != 0 && got_hdr_cnt != 0) begin
         check_val("dst_mac", got_dst, exp_dst);
         check_val("src_mac", got_src, exp_src);
         check_val("type", got_type, exp_type);
      end
      check_val("beat_cnt", got_beats.size(), exp_beats.size());
      m = (got_beats.size() < exp_beats.size()) ? got_beats.size() : exp_beats.size();
      for (int i = 0; i < m; i++) check_val("beat", got_beats[i], exp_beats[i]);
      if (exp_beats.size() > 0) begin
         check_val("last_cnt", got_last_cnt, 1);
         check_val("last_pos", got_last_idx, exp_beats.size() - 1);
         check_val("error", got_err, exp_err);
      end else begin
         check_val("last_cnt", got_last_cnt, 0);
      end
      check_val("drop_cnt", got_drop_cnt, exp_drop);
      clear_got();
      pending = 0;
   endtask

   task automatic drive_nib(input logic [3:0] n, input logic v, input logic e);
      @(negedge clk);
      rxd = n; dv = v; er = e;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic e);
      drive_nib(b[3:0], 1'b1, e);
      drive_nib(b[7:4], 1'b1, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive_nib(4'h0, 1'b0, 1'b0);
   endtask

   // The previous frame's outputs are complete a cycle after its rx_dv falls, so they are
   // compared a few cycles into the next frame's preamble.
   task automatic run_frame(input bit bad_pre, input int er_idx, input bit dribble, input int gap);
      send_byte(8'h55, 1'b0);
      send_byte(8'h55, 1'b0);
      send_byte(bad_pre ? 8'hA5 : 8'h55, 1'b0);
      if (pending) compare_pending();
      set_expect(bad_pre, er_idx >= 0, dribble);
      pending = 1;
      if (!bad_pre) begin
         for (int i = 0; i < 4; i++) send_byte(8'h55, 1'b0);
         send_byte(8'hD5, 1'b0);
      end
      for (int i = 0; i < tx_q.size(); i++) send_byte(tx_q[i], i == er_idx);
      if (dribble) drive_nib(4'($urandom), 1'b1, 1'b0);
      idle(gap);
   endtask

   task automatic finish_pending();
      idle(4);
      if (pending) compare_pending();
   endtask

   localparam logic [47:0] DST = 48'h010203040506;
   localparam logic [47:0] SRC = 48'h0A0B0C0D0E0F;

   initial begin
      logic [63:0] t1, t2;
      int plen, L, er_idx, gap;
      bit bad_fcs, bad_pre, drib;

      rst = 1'b1; rxd = 4'h0; dv = 1'b0; er = 1'b0;
      clear_got();
      repeat (3) @(negedge clk);
      check_val("rst_flags", {o_valid, o_last, o_error, o_hdr_valid, o_frame_drop}, 0);
      check_val("rst_dst", o_dst_mac, 0);
      check_val("rst_src", o_src_mac, 0);
      check_val("rst_type_data", {o_frame_type, o_data}, 0);
      rst = 1'b0;
      idle(3);

      build_frame(DST, SRC, 16'h0800, 46, 1, 0);
      run_frame(0, -1, 0, 12);
      build_frame(DST, SRC, 16'h0800, 46, 1, 1);
      run_frame(0, -1, 0, 12);
      build_frame(DST, SRC, 16'h0800, 46, 1, 0);
      run_frame(0, 14 + 20, 0, 12);
      build_frame(DST, SRC, 16'h0800, 20, 1, 0);
      run_frame(0, -1, 0, 12);
      build_frame(DST, SRC, 16'h0800, 46, 1, 0);
      while (tx_q.size() > 16) void'(tx_q.pop_back());
      run_frame(0, -1, 0, 12);
      build_frame(DST, SRC, 16'h0800, 46, 1, 0);
      run_frame(1, -1, 0, 12);
      finish_pending();

      // Reset lands at payload byte 10; nothing of that frame may surface afterwards.
      build_frame(48'hA1A2A3A4A5A6, 48'hB1B2B3B4B5B6, 16'h86DD, 46, 1, 0);
      for (int i = 0; i < 7; i++) send_byte(8'h55, 1'b0);
      send_byte(8'hD5, 1'b0);
      for (int i = 0; i < tx_q.size(); i++) begin
         if (i == 24) begin
            @(negedge clk);
            rst = 1'b1; rxd = tx_q[i][3:0]; dv = 1'b1; er = 1'b0;
            drive_nib(tx_q[i][7:4], 1'b1, 1'b0);
            @(negedge clk);
            rst = 1'b0;
            clear_got();
            if (i + 1 < tx_q.size()) begin
               rxd = tx_q[i+1][3:0];
               drive_nib(tx_q[i+1][7:4], 1'b1, 1'b0);
            end
            i++;
         end else begin
            send_byte(tx_q[i], 1'b0);
         end
      end
      idle(24);
      check_val("abort_hdr", got_hdr_cnt, 0);
      check_val("abort_beats", got_beats.size(), 0);
      check_val("abort_drop", got_drop_cnt, 0);
      check_val("abort_dst", o_dst_mac, 0);
      clear_got();
      build_frame(DST, SRC, 16'h0800, 46, 1, 0);
      run_frame(0, -1, 0, 12);

      for (int k = 0; k < 24; k++) begin
         t1 = {$urandom, $urandom};
         t2 = {$urandom, $urandom};
         plen    = $urandom_range(0, 60);
         bad_fcs = ($urandom_range(0, 3) == 0);
         build_frame(t1[47:0], t2[47:0], 16'($urandom), plen, 0, bad_fcs);
         if ($urandom_range(0, 7) == 0) begin
            L = $urandom_range(14, tx_q.size());
            while (tx_q.size() > L) void'(tx_q.pop_back());
         end
         er_idx  = ($urandom_range(0, 5) == 0) ? $urandom_range(0, tx_q.size() - 1) : -1;
         drib    = ($urandom_range(0, 5) == 0);
         bad_pre = ($urandom_range(0, 9) == 0);
         gap     = $urandom_range(1, 12);
         run_frame(bad_pre, er_idx, drib, gap);
      end

      build_frame(DST, SRC, 16'h0800, 1500, 0, 0);
      run_frame(0, -1, 0, 1);
      build_frame(DST, SRC, 16'h0800, 1501, 0, 0);
      run_frame(0, -1, 0, 2);
      finish_pending();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
